inst_encoder: RTL and testbench
===============================

# inst_encoder

Registered RV32I instruction encoder, the inverse of the core's immediate extractor. It accepts a field-level request (format, opcode, funct3/funct7, register indices, 32-bit immediate) and scatters the immediate into the instruction bit positions for R/I/S/B/U/J formats. It range-checks the immediate and buffers results in a small output FIFO with valid/ready handshakes on both sides. Consumers are the debug program-buffer writer and the self-test instruction injector ahead of the fetch mux.

## Interface
- `DEPTH`, 2: output FIFO entries (power of two, ≥2).
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_fmt`  in  5  one-hot format: bit0 I, bit1 S, bit2 B, bit3 U, bit4 J; all-zero = R-type.
- `in_opcode`  in  7  opcode field.
- `in_funct3`  in  3  funct3 field.
- `in_funct7`  in  7  funct7 field (R-type only).
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  32  byte-offset/value immediate, two's complement.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  head consumed when `out_valid & out_ready`.
- `out_inst`  out  32  encoded instruction at FIFO head.
- `out_err`  out  1  head entry failed range/format check.
- `err_cnt`  out  8  saturating count of accepted erroneous requests.

## Operation
- Encoding (`imm` = `in_imm`):
  - R: {f7, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Error conditions; `out_err`=1 marks an entry failing any of these:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]≠0.
  - `in_fmt` has more than one bit set.
  - R: imm is ignored and never flags an error.
- Erroneous entries store `out_inst`=32'h0000_0013 (canonical NOP).
- `err_cnt` increments on each accepted erroneous request and saturates at 8'hFF.
- Encode and check are combinational on the inputs. The result is written into the FIFO on the accept edge.
- FIFO: circular, read/write pointers plus occupancy count of width $clog2(DEPTH)+1. Entry = {err, inst}.
- `in_ready` = (count < DEPTH). It is registered-derived only, with no combinational path from `out_ready`.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal when full only if `in_ready` was high, which it is not, so no push occurs when full.
- Pop when empty is ignored. `out_inst`/`out_err` read the head entry directly and are don't-care when `out_valid`=0, but must not be X after reset.

## Timing
- Reset (async assert, sync-safe deassert):
  - Pointers and count 0.
  - `out_valid`=0, `in_ready`=1, `err_cnt`=0.
  - `out_inst`=0, `out_err`=0.
  - All FIFO storage cleared to 0.
- Reset mid-operation discards all buffered entries. No partial output appears after deassertion.
- Latency: a request accepted at edge N is visible with `out_valid`=1 after edge N (cycle N+1) if the FIFO was empty.
- Throughput: 1 request/cycle sustained while `out_ready`=1.
- Ordering: strictly FIFO; erroneous entries keep their slot in order.
- `out_valid`/`out_inst`/`out_err` hold stable while `out_valid & ~out_ready`.

## Test plan
- I-type: fmt=I, op=0x13, f3=0, rd=1, rs1=0, imm=5 → `out_inst`=0x00500093, `out_err`=0, one cycle after accept.
- S/B-type:
  - S: op=0x23, f3=2, rs1=1, rs2=2, imm=8 → 0x0020A423.
  - B: op=0x63, rs1=rs2=0, imm=0xFFFFFFFC → 0xFE000EE3.
- U/J-type:
  - U: op=0x37, rd=5, imm=0x12345000 → 0x123452B7.
  - J: op=0x6F, rd=1, imm=0x800 → 0x001000EF.
- Errors:
  - I imm=2048 → `out_inst`=0x00000013, `out_err`=1, `err_cnt`=1.
  - B imm=6 with imm[0]=0 → accepted without error. B imm=3 → err.
  - fmt=5'b00011 → err.
  - 256 erroneous requests → `err_cnt`=0xFF, held.
- Backpressure: DEPTH=2, `out_ready`=0, three back-to-back requests → `in_ready` low after the 2nd accept and the 3rd is held. Raise `out_ready` → 3 outputs in order, no loss or duplicates. Simultaneous push/pop at count=1 keeps count=1.
- Reset mid-stream: 2 entries buffered, pulse `rst_n` low asynchronously between edges → `out_valid`=0 and `in_ready`=1 immediately. The next request emerges alone after release.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: encodes RV32I field-level requests into instructions, range-checks immediates, buffers results in a FIFO
module inst_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [32:0]   mem_q [DEPTH];
  logic [31:0]   enc;
  logic          multi, bad, err, push, pop;
  assign in_ready  = cnt_q < (AW+1)'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign {out_err, out_inst} = mem_q[rd_q];
  assign err_cnt   = err_cnt_q;
  always_comb begin
    multi = |(in_fmt & (in_fmt - 5'd1));
    enc = in_fmt[0] ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode} :
          in_fmt[1] ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode} :
          in_fmt[2] ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode} :
          in_fmt[3] ? {in_imm[31:12], in_rd, in_opcode} :
          in_fmt[4] ? {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode} :
                      {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    bad = (in_fmt[0] | in_fmt[1]) ? !(&in_imm[31:11] | ~|in_imm[31:11]) :
          in_fmt[2] ? !(&in_imm[31:12] | ~|in_imm[31:12]) | in_imm[0] :
          in_fmt[3] ? |in_imm[11:0] :
          in_fmt[4] ? !(&in_imm[31:20] | ~|in_imm[31:20]) | in_imm[0] :
                      1'b0;
    err = multi | bad;
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    err_cnt_d = (push & err & ~&err_cnt_q) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      err_cnt_q <= err_cnt_d;
      if (push) mem_q[wr_q] <= {err, err ? 32'h0000_0013 : enc};
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: table vectors, hand sequences and a random scoreboard run against a field-level model
module tb_inst_encoder;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
  logic [4:0] in_fmt = 0, in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [6:0] in_opcode = 0, in_funct7 = 0;
  logic [2:0] in_funct3 = 0;
  logic [31:0] in_imm = 0;
  logic in_ready, out_valid, out_err;
  logic [31:0] out_inst;
  logic [7:0] err_cnt;
  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
    .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] fmt; logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [4:0] rd, rs1, rs2; logic [31:0] imm;
    logic [31:0] inst; logic err; logic [7:0] cnt;
  } vec_t;
  vec_t tbl [10];
  logic [32:0] q [$];
  int ecnt = 0, errors = 0, checks = 0;
  int bnd [14] = '{2047, 2048, -2048, -2049, 4095, 4096, -4096, -4097,
                   1048575, 1048576, -1048576, -1048577, 32'h12345000, 0};
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [31:0] fld(logic [31:0] v, int hi, int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction
  function automatic logic [32:0] model(vec_t v);
    int s = $signed(v.imm);
    logic [31:0] rd = 32'(v.rd) << 7, rs1 = 32'(v.rs1) << 15, rs2 = 32'(v.rs2) << 20;
    logic [31:0] f3 = 32'(v.f3) << 12, op = 32'(v.op), inst = 0;
    logic bad = 1;
    if ($countones(v.fmt) <= 1)
      case (v.fmt)
        5'd0:  begin inst = (32'(v.f7) << 25) | rs2 | rs1 | f3 | rd | op; bad = 0; end
        5'd1:  begin inst = (fld(v.imm, 11, 0) << 20) | rs1 | f3 | rd | op; bad = s < -2048 || s > 2047; end
        5'd2:  begin inst = (fld(v.imm, 11, 5) << 25) | rs2 | rs1 | f3 | (fld(v.imm, 4, 0) << 7) | op; bad = s < -2048 || s > 2047; end
        5'd4:  begin
          inst = (fld(v.imm, 12, 12) << 31) | (fld(v.imm, 10, 5) << 25) | rs2 | rs1 | f3 |
                 (fld(v.imm, 4, 1) << 8) | (fld(v.imm, 11, 11) << 7) | op;
          bad = s < -4096 || s > 4095 || v.imm[0];
        end
        5'd8:  begin inst = (fld(v.imm, 31, 12) << 12) | rd | op; bad = (v.imm % 4096) != 0; end
        5'd16: begin
          inst = (fld(v.imm, 20, 20) << 31) | (fld(v.imm, 10, 1) << 21) | (fld(v.imm, 11, 11) << 20) |
                 (fld(v.imm, 19, 12) << 12) | rd | op;
          bad = s < -(1 << 20) || s > (1 << 20) - 1 || v.imm[0];
        end
        default: bad = 1;
      endcase
    return bad ? {1'b1, 32'h13} : {1'b0, inst};
  endfunction
  function automatic vec_t rand_vec();
    vec_t v;
    int r = $urandom_range(0, 9);
    v.fmt = r == 0 ? 5'd0 : r <= 5 ? 5'(1 << (r - 1)) : r <= 8 ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom);
    v.op = 7'($urandom); v.f3 = 3'($urandom); v.f7 = 7'($urandom);
    v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
    r = $urandom_range(0, 3);
    v.imm = r == 0 ? $urandom : r == 1 ? 32'($urandom_range(0, 8191) - 4096) :
            r == 2 ? 32'(bnd[$urandom_range(0, 13)] + $urandom_range(0, 2) - 1) : ($urandom & ~32'hFFF);
    v.inst = 0; v.err = 0; v.cnt = 0;
    return v;
  endfunction
  task automatic apply(vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_funct3 = v.f3; in_funct7 = v.f7;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
  endtask
  task automatic step(vec_t v, logic iv, logic ordy);
    logic [32:0] e;
    logic acc, pop;
    apply(v);
    in_valid = iv;
    out_ready = ordy;
    #3;
    acc = iv && q.size() < DEPTH;
    pop = ordy && q.size() > 0;
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (pop) begin
      e = q.pop_front();
      chk("out_inst", out_inst, e[31:0]);
      chk("out_err", 32'(out_err), 32'(e[32]));
    end
    if (acc) begin
      e = model(v);
      q.push_back(e);
      if (e[32] && ecnt < 255) ecnt++;
    end
    @(posedge clk);
    #1;
    chk("err_cnt", 32'(err_cnt), 32'(ecnt));
  endtask
  initial begin
    vec_t v, idle;
    idle = rand_vec();
    tbl[0] = '{5'h01, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093, 1'b0, 8'd0};
    tbl[1] = '{5'h02, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423, 1'b0, 8'd0};
    tbl[2] = '{5'h04, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,   32'hFE000EE3, 1'b0, 8'd0};
    tbl[3] = '{5'h08, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7, 1'b0, 8'd0};
    tbl[4] = '{5'h10, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800,   32'h001000EF, 1'b0, 8'd0};
    tbl[5] = '{5'h01, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,       32'h00000013, 1'b1, 8'd1};
    tbl[6] = '{5'h04, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd6,          32'h00000363, 1'b0, 8'd1};
    tbl[7] = '{5'h04, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3,          32'h00000013, 1'b1, 8'd2};
    tbl[8] = '{5'h03, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0,          32'h00000013, 1'b1, 8'd3};
    tbl[9] = '{5'h00, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF,  32'h402081B3, 1'b0, 8'd3};
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst err_cnt", 32'(err_cnt), 0);
    chk("rst out_inst", out_inst, 0);
    chk("rst out_err", 32'(out_err), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      in_valid = 1;
      out_ready = 1;
      @(posedge clk);
      #1;
      in_valid = 0;
      chk($sformatf("vec%0d valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d inst", i), out_inst, tbl[i].inst);
      chk($sformatf("vec%0d err", i), 32'(out_err), 32'(tbl[i].err));
      chk($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(tbl[i].cnt));
      @(posedge clk);
      #1;
    end
    chk("table drained", 32'(out_valid), 0);
    ecnt = 3;
    repeat (2000) step(rand_vec(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    repeat (3) step(idle, 0, 1);
    // backpressure: third request must stall until a slot frees, then order is preserved
    step(rand_vec(), 1, 0);
    step(rand_vec(), 1, 0);
    chk("full in_ready", 32'(in_ready), 0);
    v = rand_vec();
    step(v, 1, 0);
    step(v, 1, 1);
    step(v, 1, 1);
    step(rand_vec(), 1, 1);
    chk("push+pop valid", 32'(out_valid), 1);
    chk("push+pop in_ready", 32'(in_ready), 1);
    step(idle, 0, 1);
    chk("count1 drained", 32'(out_valid), 0);
    v = rand_vec();
    v.fmt = 5'b00011;
    repeat (260) step(v, 1, 1);
    chk("err_cnt saturated", 32'(err_cnt), 255);
    repeat (2) step(idle, 0, 1);
    step(rand_vec(), 1, 0);
    step(rand_vec(), 1, 0);
    in_valid = 0;
    #3 rst_n = 0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst in_ready", 32'(in_ready), 1);
    chk("midrst err_cnt", 32'(err_cnt), 0);
    chk("midrst out_inst", out_inst, 0);
    q.delete();
    ecnt = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    step(rand_vec(), 1, 1);
    step(idle, 0, 1);
    step(idle, 0, 1);
    chk("post-reset alone", 32'(out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
